// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads the
// IF/ID register; also tracks a sticky fetch error and a saturating retire count.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          IMEM_AW  = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               fetch_err,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] FETCH_LIMIT = 32'd4 << IMEM_AW;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_off, pc_plus4;
  logic        in_range;

  // Offset wraps for PCs below the text base, so one unsigned compare covers both ends.
  assign pc_off    = pc_q - RESET_PC;
  assign pc_plus4  = pc_q + 32'd4;
  assign in_range  = pc_off < FETCH_LIMIT;
  assign imem_addr = pc_off[IMEM_AW+1:2];

  always_comb begin
    pc_d    = pc_plus4;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) err_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (!in_range) begin
      instr_d = 32'd0;
      pc4_d   = pc_plus4;
      valid_d = 1'b0;
      err_d   = 1'b1;
    end else begin
      instr_d = imem_dout;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fetch_err   = err_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a vector table of per-edge inputs and expected
// state, plus hand sequences for a long run and an asynchronous mid-run reset.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] pc, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, fetch_err;

  logic [31:0] mem [512];
  int tests = 0;
  int fails = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_dout = mem[imem_addr];

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [8:0]  addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        err;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic st, logic rv, logic [31:0] rpc, logic [31:0] epc,
                              logic [8:0] addr, logic v, logic [31:0] instr,
                              logic [31:0] pc4, logic err, logic [31:0] cnt);
    vec_t r;
    r.st = st; r.rv = rv; r.rpc = rpc; r.pc = epc; r.addr = addr; r.v = v;
    r.instr = instr; r.pc4 = pc4; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [31:0] epc, logic [8:0] addr, logic v,
                         logic [31:0] instr, logic [31:0] pc4, logic err, logic [31:0] cnt);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".imem_addr"}, {23'd0, imem_addr}, {23'd0, addr});
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc4"}, if_id_pc4, pc4);
    chk({tag, ".err"}, {31'd0, fetch_err}, {31'd0, err});
    chk({tag, ".count"}, fetch_count, cnt);
  endtask

  task automatic step(logic st, logic rv, logic [31:0] rpc);
    stall = st; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h3c011001;
    mem[1] = 32'h343a0000;

    //               st rv rpc           pc            addr    v  instr         pc4           err cnt
    tbl[0]  = mk(0, 0, 32'h0,        32'h00400004, 9'h001, 1, 32'h3c011001, 32'h00400004, 0, 1);
    tbl[1]  = mk(0, 0, 32'h0,        32'h00400008, 9'h002, 1, 32'h343a0000, 32'h00400008, 0, 2);
    tbl[2]  = mk(0, 1, 32'h004001C8, 32'h004001C8, 9'h072, 0, 32'h0,        32'h0,        0, 2);
    tbl[3]  = mk(0, 0, 32'h0,        32'h004001CC, 9'h073, 1, 32'h10000072, 32'h004001CC, 0, 3);
    tbl[4]  = mk(0, 0, 32'h0,        32'h004001D0, 9'h074, 1, 32'h10000073, 32'h004001D0, 0, 4);
    tbl[5]  = mk(1, 0, 32'h0,        32'h004001D0, 9'h074, 1, 32'h10000073, 32'h004001D0, 0, 4);
    tbl[6]  = mk(1, 0, 32'h0,        32'h004001D0, 9'h074, 1, 32'h10000073, 32'h004001D0, 0, 4);
    tbl[7]  = mk(1, 0, 32'h0,        32'h004001D0, 9'h074, 1, 32'h10000073, 32'h004001D0, 0, 4);
    tbl[8]  = mk(0, 0, 32'h0,        32'h004001D4, 9'h075, 1, 32'h10000074, 32'h004001D4, 0, 5);
    tbl[9]  = mk(1, 1, 32'h00400020, 32'h00400020, 9'h008, 0, 32'h0,        32'h0,        0, 5);
    tbl[10] = mk(0, 0, 32'h0,        32'h00400024, 9'h009, 1, 32'h10000008, 32'h00400024, 0, 6);
    tbl[11] = mk(0, 1, 32'h00400006, 32'h00400004, 9'h001, 0, 32'h0,        32'h0,        1, 6);
    tbl[12] = mk(0, 0, 32'h0,        32'h00400008, 9'h002, 1, 32'h343a0000, 32'h00400008, 1, 7);
    // out-of-range fetch: word 512 truncates to address 0 but must bubble
    tbl[13] = mk(0, 1, 32'h00400800, 32'h00400800, 9'h000, 0, 32'h0,        32'h0,        1, 17);
    tbl[14] = mk(0, 0, 32'h0,        32'h00400804, 9'h001, 0, 32'h0,        32'h00400804, 1, 17);
    tbl[15] = mk(0, 0, 32'h0,        32'h00400808, 9'h002, 0, 32'h0,        32'h00400808, 1, 17);
    tbl[16] = mk(0, 1, 32'h00400000, 32'h00400000, 9'h000, 0, 32'h0,        32'h0,        1, 17);
    tbl[17] = mk(0, 0, 32'h0,        32'h00400004, 9'h001, 1, 32'h3c011001, 32'h00400004, 1, 18);
    // below the text base: offset wraps, still out of range
    tbl[18] = mk(0, 1, 32'h003FFFFC, 32'h003FFFFC, 9'h1FF, 0, 32'h0,        32'h0,        1, 18);
    tbl[19] = mk(0, 0, 32'h0,        32'h00400000, 9'h000, 0, 32'h0,        32'h00400000, 1, 18);
    tbl[20] = mk(0, 0, 32'h0,        32'h00400004, 9'h001, 1, 32'h3c011001, 32'h00400004, 1, 19);

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    chk_all("reset", 32'h00400000, 9'h000, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // the edge where rst is released is the first fetch edge only if rst dropped before it
    chk_all("first", 32'h00400004, 9'h001, 1, 32'h3c011001, 32'h00400004, 0, 1);

    for (int i = 1; i < 21; i++) begin
      step(tbl[i].st, tbl[i].rv, tbl[i].rpc);
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].addr, tbl[i].v, tbl[i].instr,
              tbl[i].pc4, tbl[i].err, tbl[i].cnt);
      if (i == 12) begin
        for (int k = 0; k < 10; k++) begin
          step(0, 0, 32'h0);
          chk_all($sformatf("run%0d", k), 32'h0040000C + 4 * k, 9'(3 + k), 1,
                  32'h10000002 + k, 32'h0040000C + 4 * k, 1, 8 + k);
        end
      end
    end

    // asynchronous reset between edges clears everything without a clock
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h00400000, 9'h000, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 32'h0);
    chk_all("post_rst", 32'h00400004, 9'h001, 1, 32'h3c011001, 32'h00400004, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
